// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-interface arbiter.
//   state_e          : arbiter FSM states
//   RSP_TIMEOUT_DATA : read data returned with a timed-out response
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_RSP  = 2'd1,
      RD_WAIT = 2'd2,
      RD_RSP  = 2'd3
   } state_e;

   // Wide enough for any sensible register width; users truncate to RegDw.
   localparam logic [255:0] RSP_TIMEOUT_DATA = '0;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i : per-requester request vector
//   ptr_i : index of the highest-priority requester this cycle
//   gnt_o : one-hot winner (all zero when nothing is requested)
//   idx_o : binary index of the winner (0 when nothing is requested)
module reg_arb_rr_pick #(
   parameter int unsigned NumReq = 2,
   localparam int unsigned IdxW  = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o
);

   int   cand;
   logic found;

   // NOTE: every variable written in an always_comb gets a default first, so
   // no path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      idx_o = '0;
      found = 1'b0;
      cand  = 0;
      // Scan from the pointer upward, wrapping once; first hit wins.
      for (int i = 0; i < int'(NumReq); i++) begin
         cand = int'(ptr_i) + i;
         if (cand >= int'(NumReq)) begin
            cand = cand - int'(NumReq);
         end
         if (!found && req_i[IdxW'(cand)]) begin
            found = 1'b1;
            idx_o = IdxW'(cand);
         end
      end
      gnt_o = found ? (NumReq'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/reg_if_arbiter.sv
// Shares one register interface among NumReq requesters (TL-UL register
// adapter, LLKI key-load engine). Round-robin grant, one transaction in
// flight, read latency bounded by a timeout that forces an error response.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/be_i : per-requester request, held until gnt_o
//   gnt_o                : one-hot acceptance pulse
//   rsp_valid_o          : one-hot response pulse to the granted requester
//   rsp_rdata_o/rsp_error_o : shared response payload, valid with rsp_valid_o
//   re_o/we_o/addr_o/wdata_o/be_o : downstream strobes and winner's request
//   rdata_i/rdata_valid_i/error_i : downstream read data, its valid, error
//   spurious_o           : pulse when rdata_valid_i arrives with no read pending
module reg_if_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned RegAw         = 8,
   parameter int unsigned RegDw         = 32,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumReq-1:0]              req_i,
   input  logic [NumReq-1:0]              we_i,
   input  logic [NumReq*RegAw-1:0]        addr_i,
   input  logic [NumReq*RegDw-1:0]        wdata_i,
   input  logic [NumReq*(RegDw/8)-1:0]    be_i,
   output logic [NumReq-1:0]              gnt_o,
   output logic [NumReq-1:0]              rsp_valid_o,
   output logic [RegDw-1:0]               rsp_rdata_o,
   output logic                           rsp_error_o,
   output logic                           re_o,
   output logic                           we_o,
   output logic [RegAw-1:0]               addr_o,
   output logic [RegDw-1:0]               wdata_o,
   output logic [RegDw/8-1:0]             be_o,
   input  logic [RegDw-1:0]               rdata_i,
   input  logic                           rdata_valid_i,
   input  logic                           error_i,
   output logic                           spurious_o
);

   localparam int unsigned IdxW = $clog2(NumReq);
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam int unsigned BeW  = RegDw / 8;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   win_q, win_d;
   logic              err_q, err_d;
   logic [RegDw-1:0]  rdata_q, rdata_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              spurious_q, spurious_d;

   logic [NumReq-1:0] pick_gnt;
   logic [IdxW-1:0]   pick_idx;
   logic              issue;
   logic              pick_we;

   reg_arb_rr_pick #(.NumReq(NumReq)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // Reset is folded in so the combinational outputs read 0 while it is held.
   assign issue   = (state_q == IDLE) && (|req_i) && !rst_i;
   assign pick_we = |(we_i & pick_gnt);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      // Data arriving when no read is waiting is dropped and flagged.
      spurious_d = rdata_valid_i && (state_q != RD_WAIT);
      unique case (state_q)
         IDLE: begin
            if (issue) begin
               win_d   = pick_idx;
               err_d   = error_i;
               rdata_d = '0;
               ptr_d   = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + IdxW'(1);
               if (pick_we) begin
                  state_d = WR_RSP;
               end else begin
                  state_d = RD_WAIT;
                  cnt_d   = '0;
               end
            end
         end
         WR_RSP: state_d = IDLE;
         RD_WAIT: begin
            // Data beats expiry when both land in the same cycle.
            if (rdata_valid_i) begin
               rdata_d = rdata_i;
               state_d = RD_RSP;
            end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               rdata_d = RSP_TIMEOUT_DATA[RegDw-1:0];
               err_d   = 1'b1;
               state_d = RD_RSP;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RD_RSP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Downstream request: winner's fields, zero whenever nothing issues.
   always_comb begin
      gnt_o   = '0;
      re_o    = 1'b0;
      we_o    = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      be_o    = '0;
      if (issue) begin
         gnt_o = pick_gnt;
         we_o  = pick_we;
         re_o  = !pick_we;
         for (int i = 0; i < int'(NumReq); i++) begin
            if (pick_gnt[i]) begin
               addr_o  = addr_i[i*RegAw +: RegAw];
               wdata_o = wdata_i[i*RegDw +: RegDw];
               be_o    = be_i[i*BeW +: BeW];
            end
         end
      end
   end

   always_comb begin
      rsp_valid_o = '0;
      rsp_rdata_o = '0;
      rsp_error_o = 1'b0;
      if (state_q == WR_RSP || state_q == RD_RSP) begin
         rsp_valid_o = NumReq'(1) << win_q;
         rsp_error_o = err_q;
         rsp_rdata_o = (state_q == RD_RSP) ? rdata_q : '0;
      end
   end

   assign spurious_o = spurious_q;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         win_q      <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         spurious_q <= spurious_d;
      end
   end

endmodule

// File: tb/tb_reg_if_arbiter.sv
`timescale 1ns/1ps
module tb_reg_if_arbiter;

   localparam int NumReq = 2;
   localparam int RegAw  = 8;
   localparam int RegDw  = 32;
   localparam int TimeoutCycles = 8;

   typedef struct packed {
      logic [1:0]  who;
      logic [31:0] data;
      logic        err;
      logic [31:0] cyc;
   } rsp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_i, we_i;
   logic [15:0] addr_i;
   logic [63:0] wdata_i;
   logic [7:0]  be_i;
   logic [1:0]  gnt_o, rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_error_o, re_o, we_o;
   logic [7:0]  addr_o;
   logic [31:0] wdata_o;
   logic [3:0]  be_o;
   logic [31:0] rdata_i;
   logic        rdata_valid_i, error_i, spurious_o;

   rsp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc_cnt = 0;

   reg_if_arbiter #(
      .NumReq(NumReq), .RegAw(RegAw), .RegDw(RegDw), .TimeoutCycles(TimeoutCycles)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o), .re_o(re_o), .we_o(we_o),
      .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i),
      .rdata_valid_i(rdata_valid_i), .error_i(error_i), .spurious_o(spurious_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   function automatic string fmt(input rsp_t r);
      return $sformatf("who=%b data=%h err=%b cyc=%0d", r.who, r.data, r.err, r.cyc);
   endfunction

   // Advance to just after the next n rising edges (the drive point).
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Present a request until granted (bounded); report what the DUT showed.
   task automatic issue(input logic [1:0] mask, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic err,
                        output logic [1:0] g, output logic re_obs, output logic we_obs,
                        output logic [7:0] a_obs, output int gc);
      logic done;
      done    = 1'b0;
      g       = '0;
      re_obs  = 1'b0;
      we_obs  = 1'b0;
      a_obs   = '0;
      gc      = -1;
      req_i   = mask;
      we_i    = {wr, wr};
      addr_i  = {addr ^ 8'h80, addr};
      wdata_i = {~wdata, wdata};
      be_i    = 8'hC3;
      error_i = err;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk_i);
         if (gnt_o != '0) begin
            g      = gnt_o;
            re_obs = re_o;
            we_obs = we_o;
            a_obs  = addr_o;
            gc     = cyc_cnt;
            done   = 1'b1;
         end
         @(posedge clk_i);
         #1;
      end
      req_i   = '0;
      error_i = 1'b0;
   endtask

   // Wait (bounded) for a response; all-zero result when none arrives.
   task automatic wait_rsp(input int budget, output rsp_t obs);
      logic done;
      done = 1'b0;
      obs  = '0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk_i);
         if (rsp_valid_o != '0) begin
            obs.who  = rsp_valid_o;
            obs.data = rsp_rdata_o;
            obs.err  = rsp_error_o;
            obs.cyc  = 32'(cyc_cnt);
            done     = 1'b1;
         end
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [85:0] outs;
      rst_i = 1'b1;
      req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
      rdata_i = '0; rdata_valid_i = 1'b0; error_i = 1'b0;
      tick(2);
      @(negedge clk_i);
      outs = {gnt_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, re_o, we_o, addr_o, wdata_o, be_o, spurious_o};
      n_total++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
      else n_pass++;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tick(1);
   endtask

   task automatic test_fairness();
      logic [1:0] exp_g;
      rsp_t       obs, exp;
      req_i   = 2'b11;
      we_i    = 2'b11;
      addr_i  = {8'h21, 8'h20};
      wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
      be_i    = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         exp_g = (k % 2 != 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
         n_total++;
         if (gnt_o !== exp_g) $display("FAIL fair_gnt[%0d]: got %b want %b", k, gnt_o, exp_g);
         else n_pass++;
         if (gnt_o != '0) begin
            n_total++;
            if (we_o !== 1'b1 || addr_o !== ((gnt_o == 2'b01) ? 8'h20 : 8'h21))
               $display("FAIL fair_mux[%0d]: got we=%b addr=%h", k, we_o, addr_o);
            else n_pass++;
            exp_q.push_back('{who: gnt_o, data: 32'h0, err: 1'b0, cyc: 32'(cyc_cnt + 1)});
         end
         if (rsp_valid_o != '0) begin
            obs = '{who: rsp_valid_o, data: rsp_rdata_o, err: rsp_error_o, cyc: 32'(cyc_cnt)};
            n_total++;
            if (exp_q.size() == 0) $display("FAIL fair_rsp[%0d]: got %s want none", k, fmt(obs));
            else begin
               exp = exp_q.pop_front();
               if (obs !== exp) $display("FAIL fair_rsp[%0d]: got %s want %s", k, fmt(obs), fmt(exp));
               else n_pass++;
            end
         end
         @(posedge clk_i);
         #1;
      end
      req_i = '0;
      tick(1);
   endtask

   task automatic test_read();
      logic [1:0] g; logic re_obs, we_obs; logic [7:0] a_obs; int gc;
      rsp_t obs, exp;
      issue(2'b01, 1'b0, 8'h10, 32'h0, 1'b0, g, re_obs, we_obs, a_obs, gc);
      n_total++;
      if (g !== 2'b01 || re_obs !== 1'b1 || we_obs !== 1'b0 || a_obs !== 8'h10)
         $display("FAIL read_issue: got gnt=%b re=%b we=%b addr=%h want 01 1 0 10", g, re_obs, we_obs, a_obs);
      else n_pass++;
      exp_q.push_back('{who: 2'b01, data: 32'hA5A5_A5A5, err: 1'b0, cyc: 32'(gc + 4)});
      tick(2);
      rdata_valid_i = 1'b1;
      rdata_i       = 32'hA5A5_A5A5;
      tick(1);
      rdata_valid_i = 1'b0;
      wait_rsp(20, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (obs !== exp) $display("FAIL read_rsp: got %s want %s", fmt(obs), fmt(exp));
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [1:0] g; logic re_obs, we_obs; logic [7:0] a_obs; int gc;
      rsp_t obs, exp;
      issue(2'b10, 1'b0, 8'h33, 32'h0, 1'b0, g, re_obs, we_obs, a_obs, gc);
      n_total++;
      if (g !== 2'b10 || a_obs !== 8'hB3) $display("FAIL tmo_issue: got gnt=%b addr=%h want 10 b3", g, a_obs);
      else n_pass++;
      exp_q.push_back('{who: 2'b10, data: 32'h0, err: 1'b1, cyc: 32'(gc + 9)});
      wait_rsp(20, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (obs !== exp) $display("FAIL tmo_rsp: got %s want %s", fmt(obs), fmt(exp));
      else n_pass++;
      // Late data after the timeout.
      rdata_valid_i = 1'b1;
      rdata_i       = 32'hDEAD_BEEF;
      tick(1);
      rdata_valid_i = 1'b0;
      @(negedge clk_i);
      n_total++;
      if (spurious_o !== 1'b1 || rsp_valid_o !== 2'b00)
         $display("FAIL tmo_spurious: got spurious=%b rsp_valid=%b want 1 00", spurious_o, rsp_valid_o);
      else n_pass++;
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      n_total++;
      if (spurious_o !== 1'b0) $display("FAIL tmo_spurious_pulse: got %b want 0", spurious_o);
      else n_pass++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_collision();
      logic [1:0] g; logic re_obs, we_obs; logic [7:0] a_obs; int gc;
      rsp_t obs, exp;
      issue(2'b01, 1'b0, 8'h44, 32'h0, 1'b0, g, re_obs, we_obs, a_obs, gc);
      exp_q.push_back('{who: 2'b01, data: 32'h0000_1234, err: 1'b0, cyc: 32'(gc + 9)});
      tick(7);
      rdata_valid_i = 1'b1;
      rdata_i       = 32'h0000_1234;
      tick(1);
      rdata_valid_i = 1'b0;
      wait_rsp(20, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (obs !== exp) $display("FAIL collision_rsp: got %s want %s", fmt(obs), fmt(exp));
      else n_pass++;
   endtask

   task automatic test_write_error();
      logic [1:0] g; logic re_obs, we_obs; logic [7:0] a_obs; int gc;
      rsp_t obs, exp;
      issue(2'b10, 1'b1, 8'h55, 32'h1111_2222, 1'b1, g, re_obs, we_obs, a_obs, gc);
      n_total++;
      if (g !== 2'b10 || we_obs !== 1'b1 || re_obs !== 1'b0)
         $display("FAIL werr_issue: got gnt=%b we=%b re=%b want 10 1 0", g, we_obs, re_obs);
      else n_pass++;
      exp_q.push_back('{who: 2'b10, data: 32'h0, err: 1'b1, cyc: 32'(gc + 1)});
      wait_rsp(10, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (obs !== exp) $display("FAIL werr_rsp: got %s want %s", fmt(obs), fmt(exp));
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic [1:0] g; logic re_obs, we_obs; logic [7:0] a_obs; int gc;
      logic [85:0] outs;
      int   n_rsp;
      rsp_t obs, exp;
      // Leaves the round-robin pointer at 1 before the abort.
      issue(2'b01, 1'b0, 8'h66, 32'h0, 1'b0, g, re_obs, we_obs, a_obs, gc);
      tick(2);
      rst_i = 1'b1;
      @(negedge clk_i);
      outs = {gnt_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, re_o, we_o, addr_o, wdata_o, be_o, spurious_o};
      n_total++;
      if (outs !== '0) $display("FAIL midrst_outputs: got %h want 0", outs);
      else n_pass++;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      n_rsp = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_i);
         if (rsp_valid_o != '0) n_rsp++;
         @(posedge clk_i);
         #1;
      end
      n_total++;
      if (n_rsp !== 0) $display("FAIL midrst_no_rsp: got %0d responses want 0", n_rsp);
      else n_pass++;
      issue(2'b11, 1'b1, 8'h40, 32'h7777_8888, 1'b0, g, re_obs, we_obs, a_obs, gc);
      n_total++;
      if (g !== 2'b01 || a_obs !== 8'h40) $display("FAIL midrst_regrant: got gnt=%b addr=%h want 01 40", g, a_obs);
      else n_pass++;
      exp_q.push_back('{who: 2'b01, data: 32'h0, err: 1'b0, cyc: 32'(gc + 1)});
      wait_rsp(10, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (obs !== exp) $display("FAIL midrst_rsp: got %s want %s", fmt(obs), fmt(exp));
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_read();
      test_timeout();
      test_collision();
      test_write_error();
      test_reset_mid_read();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
